// File: rtl/cva6_lockstep_sync_ctrl.sv
// Per-group lockstep synchronisation controller: each redundant group of GroupSize
// harts independently gathers sync requests, applies a timed core setback and holds lockstep.
module cva6_lockstep_sync_ctrl #(
    parameter int unsigned NumHarts      = 4,
    parameter int unsigned GroupSize     = 2,
    parameter int unsigned SetbackCycles = 4,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned ErrCntWidth   = 8,
    localparam int unsigned NumGroups    = NumHarts / GroupSize
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [NumGroups-1:0]               grp_enable_i,
    input  logic [NumHarts-1:0]                harts_sync_req_i,
    input  logic [NumGroups-1:0]               grp_mismatch_i,
    output logic [NumHarts-1:0]                core_setback_o,
    output logic [NumGroups-1:0]               grp_locked_o,
    output logic [NumGroups-1:0]               grp_resync_req_o,
    output logic [NumGroups-1:0]               grp_timeout_o,
    output logic [NumGroups*ErrCntWidth-1:0]   grp_err_cnt_o
);

    // One timer serves both the sync timeout and the setback duration.
    localparam int unsigned TimerMax   = (TimeoutCycles > SetbackCycles) ? TimeoutCycles : SetbackCycles;
    localparam int unsigned TimerWidth = $clog2(TimerMax);
    localparam int unsigned UsedHarts  = NumGroups * GroupSize;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        SETBACK,
        LOCKED,
        RESYNC
    } state_e;

    for (genvar g = 0; g < NumGroups; g++) begin : gen_group
        state_e                   state_q, state_d;
        logic [TimerWidth-1:0]    timer_q, timer_d;
        logic                     timeout_q, timeout_d;
        logic [ErrCntWidth-1:0]   err_q, err_d;
        logic                     all_req;

        assign all_req = &harts_sync_req_i[g*GroupSize +: GroupSize];

        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                state_q   <= IDLE;
                timer_q   <= '0;
                timeout_q <= 1'b0;
                err_q     <= '0;
            end else begin
                state_q   <= state_d;
                timer_q   <= timer_d;
                timeout_q <= timeout_d;
                err_q     <= err_d;
            end
        end

        // NOTE: every signal gets a default before the case so no path can infer a latch.
        always_comb begin
            state_d   = state_q;
            timer_d   = timer_q;
            timeout_d = timeout_q;
            err_d     = err_q;
            case (state_q)
                IDLE: begin
                    if (grp_enable_i[g]) begin
                        state_d   = WAIT_SYNC;
                        timer_d   = '0;
                        timeout_d = 1'b0;
                    end
                end
                WAIT_SYNC: begin
                    timer_d = timer_q + TimerWidth'(1);
                    if (!grp_enable_i[g]) begin
                        state_d = IDLE;
                    end else if (all_req) begin
                        state_d = SETBACK;
                        timer_d = '0;
                    end else if (timer_q == TimerWidth'(TimeoutCycles - 1)) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
                SETBACK: begin
                    // Enable is deliberately ignored: a started setback always runs to completion.
                    if (timer_q == TimerWidth'(SetbackCycles - 1)) begin
                        state_d = LOCKED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TimerWidth'(1);
                    end
                end
                LOCKED: begin
                    if (grp_mismatch_i[g]) begin
                        state_d = RESYNC;
                        if (err_q != '1) begin
                            err_d = err_q + ErrCntWidth'(1);
                        end
                    end
                    if (!grp_enable_i[g]) begin
                        state_d = IDLE;
                    end
                end
                RESYNC: begin
                    state_d = WAIT_SYNC;
                    timer_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end

        assign core_setback_o[g*GroupSize +: GroupSize]   = {GroupSize{state_q == SETBACK}};
        assign grp_locked_o[g]                            = (state_q == LOCKED);
        assign grp_resync_req_o[g]                        = (state_q == RESYNC);
        assign grp_timeout_o[g]                           = timeout_q;
        assign grp_err_cnt_o[g*ErrCntWidth +: ErrCntWidth] = err_q;
    end

    // Harts beyond the last full group never take part in lockstep.
    if (NumHarts > UsedHarts) begin : gen_leftover
        logic unused_leftover_req;
        assign core_setback_o[NumHarts-1:UsedHarts] = '0;
        assign unused_leftover_req                  = ^harts_sync_req_i[NumHarts-1:UsedHarts];
    end

endmodule

// File: tb/tb_cva6_lockstep_sync_ctrl.sv
// Self-checking bench for cva6_lockstep_sync_ctrl: 5 harts in two DMR groups plus one
// leftover hart, short timeout and a 2-bit error counter so saturation is reachable.
module tb_cva6_lockstep_sync_ctrl;

    localparam int NH = 5;
    localparam int GS = 2;
    localparam int SB = 4;
    localparam int TO = 16;
    localparam int EW = 2;
    localparam int NG = NH / GS;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [NG-1:0]     grp_enable_i;
    logic [NH-1:0]     harts_sync_req_i;
    logic [NG-1:0]     grp_mismatch_i;
    logic [NH-1:0]     core_setback_o;
    logic [NG-1:0]     grp_locked_o;
    logic [NG-1:0]     grp_resync_req_o;
    logic [NG-1:0]     grp_timeout_o;
    logic [NG*EW-1:0]  grp_err_cnt_o;

    cva6_lockstep_sync_ctrl #(
        .NumHarts      (NH),
        .GroupSize     (GS),
        .SetbackCycles (SB),
        .TimeoutCycles (TO),
        .ErrCntWidth   (EW)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .grp_enable_i     (grp_enable_i),
        .harts_sync_req_i (harts_sync_req_i),
        .grp_mismatch_i   (grp_mismatch_i),
        .core_setback_o   (core_setback_o),
        .grp_locked_o     (grp_locked_o),
        .grp_resync_req_o (grp_resync_req_o),
        .grp_timeout_o    (grp_timeout_o),
        .grp_err_cnt_o    (grp_err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {EV_SETBACK, EV_RESYNC, EV_TIMEOUT} ev_e;
    typedef struct {
        ev_e kind;
        int  grp;
        int  len;
    } ev_t;

    ev_t          exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [EW-1:0] exp_err [NG];

    int   sb_len [NG];
    int   rs_len [NG];
    logic to_prev [NG];

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic expect_ev(input ev_e kind, input int grp, input int len);
        ev_t e;
        e.kind = kind;
        e.grp  = grp;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_e kind, input int grp, input int len);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s g%0d len=%0d, required none", kind.name(), grp, len);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.grp != grp || e.len != len) begin
                errors++;
                $display("FAIL event: got %s g%0d len=%0d, required %s g%0d len=%0d",
                         kind.name(), grp, len, e.kind.name(), e.grp, e.len);
            end
        end
    endtask

    // Monitor: turns output pulses into events and matches them against the expected queue.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            for (int g = 0; g < NG; g++) begin
                sb_len[g]  = 0;
                rs_len[g]  = 0;
                to_prev[g] = 1'b0;
            end
        end else begin
            for (int g = 0; g < NG; g++) begin
                if (core_setback_o[g*GS +: GS] == 2'b11) begin
                    sb_len[g]++;
                end else begin
                    if (core_setback_o[g*GS +: GS] != 2'b00) begin
                        checks++;
                        errors++;
                        $display("FAIL setback_members g%0d: got %b, required 00 or 11", g, core_setback_o[g*GS +: GS]);
                    end
                    if (sb_len[g] != 0) observe(EV_SETBACK, g, sb_len[g]);
                    sb_len[g] = 0;
                end
                if (grp_resync_req_o[g]) begin
                    rs_len[g]++;
                end else begin
                    if (rs_len[g] != 0) observe(EV_RESYNC, g, rs_len[g]);
                    rs_len[g] = 0;
                end
                if (grp_timeout_o[g] && !to_prev[g]) observe(EV_TIMEOUT, g, 1);
                to_prev[g] = grp_timeout_o[g];
            end
        end
    end

    task automatic wait_locked(input int g);
        int n = 0;
        while (grp_locked_o[g] !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        checks++;
        if (grp_locked_o[g] !== 1'b1) begin
            errors++;
            $display("FAIL lock_wait g%0d: locked=%b after %0d cycles, required 1", g, grp_locked_o[g], n);
        end
    endtask

    // Mismatch pulse on a locked group whose members keep requesting sync.
    task automatic do_mismatch(input int g);
        grp_mismatch_i[g] = 1'b1;
        exp_err[g] = (exp_err[g] == '1) ? exp_err[g] : exp_err[g] + 1'b1;
        expect_ev(EV_RESYNC, g, 1);
        expect_ev(EV_SETBACK, g, SB);
        tick(1);
        grp_mismatch_i[g] = 1'b0;
        checks++;
        if (grp_resync_req_o[g] !== 1'b1) begin
            errors++;
            $display("FAIL resync_latency g%0d: got %b, required 1", g, grp_resync_req_o[g]);
        end
        checks++;
        if (grp_err_cnt_o[g*EW +: EW] !== exp_err[g]) begin
            errors++;
            $display("FAIL err_cnt g%0d: got %0d, required %0d", g, grp_err_cnt_o[g*EW +: EW], exp_err[g]);
        end
        wait_locked(g);
    endtask

    task automatic test_reset();
        checks++;
        if (core_setback_o !== '0) begin errors++; $display("FAIL reset_setback: got %b, required 0", core_setback_o); end
        checks++;
        if (grp_locked_o !== '0) begin errors++; $display("FAIL reset_locked: got %b, required 0", grp_locked_o); end
        checks++;
        if (grp_resync_req_o !== '0) begin errors++; $display("FAIL reset_resync: got %b, required 0", grp_resync_req_o); end
        checks++;
        if (grp_timeout_o !== '0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", grp_timeout_o); end
        checks++;
        if (grp_err_cnt_o !== '0) begin errors++; $display("FAIL reset_err_cnt: got %h, required 0", grp_err_cnt_o); end
    endtask

    task automatic test_sync_lock();
        grp_enable_i[0] = 1'b1;
        tick(3);
        harts_sync_req_i[0] = 1'b1;
        tick(4);
        checks++;
        if (core_setback_o[1:0] !== 2'b00) begin errors++; $display("FAIL partial_sync: got %b, required 00", core_setback_o[1:0]); end
        harts_sync_req_i[1] = 1'b1;
        expect_ev(EV_SETBACK, 0, SB);
        tick(1);
        checks++;
        if (core_setback_o[1:0] !== 2'b11) begin errors++; $display("FAIL setback_start: got %b, required 11", core_setback_o[1:0]); end
        checks++;
        if (core_setback_o[4:2] !== 3'b000) begin errors++; $display("FAIL other_group_setback: got %b, required 000", core_setback_o[4:2]); end
        tick(SB);
        checks++;
        if (grp_locked_o !== 2'b01) begin errors++; $display("FAIL locked_after_setback: got %b, required 01", grp_locked_o); end
        checks++;
        if (core_setback_o !== '0) begin errors++; $display("FAIL setback_end: got %b, required 0", core_setback_o); end
    endtask

    task automatic test_mismatch_count();
        for (int i = 0; i < 3; i++) do_mismatch(0);
        checks++;
        if (grp_err_cnt_o[1:0] !== 2'd3) begin errors++; $display("FAIL err_cnt_three: got %0d, required 3", grp_err_cnt_o[1:0]); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 2; i++) do_mismatch(0);
        checks++;
        if (grp_err_cnt_o[1:0] !== 2'd3) begin errors++; $display("FAIL err_cnt_saturate: got %0d, required 3", grp_err_cnt_o[1:0]); end
    endtask

    task automatic test_timeout();
        harts_sync_req_i[2] = 1'b1;
        grp_enable_i[1] = 1'b1;
        tick(1);
        tick(TO - 1);
        checks++;
        if (grp_timeout_o[1] !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b, required 0", grp_timeout_o[1]); end
        expect_ev(EV_TIMEOUT, 1, 1);
        tick(1);
        checks++;
        if (grp_timeout_o[1] !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b, required 1", grp_timeout_o[1]); end
        grp_enable_i[1] = 1'b0;
        tick(1);
        checks++;
        if (grp_timeout_o[1] !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b, required 1", grp_timeout_o[1]); end
        checks++;
        if (grp_locked_o !== 2'b01) begin errors++; $display("FAIL timeout_locked: got %b, required 01", grp_locked_o); end
        checks++;
        if (core_setback_o[3:2] !== 2'b00) begin errors++; $display("FAIL timeout_setback: got %b, required 00", core_setback_o[3:2]); end
        grp_enable_i[1] = 1'b1;
        tick(1);
        checks++;
        if (grp_timeout_o[1] !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b, required 0", grp_timeout_o[1]); end
        grp_enable_i[1] = 1'b0;
        tick(1);
        harts_sync_req_i[2] = 1'b0;
        tick(2);
        checks++;
        if (grp_timeout_o[1] !== 1'b0) begin errors++; $display("FAIL disable_no_timeout: got %b, required 0", grp_timeout_o[1]); end
    endtask

    task automatic test_leftover_and_disable();
        grp_mismatch_i[1] = 1'b1;
        tick(1);
        grp_mismatch_i[1] = 1'b0;
        checks++;
        if (grp_err_cnt_o[3:2] !== 2'd0 || grp_resync_req_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL idle_mismatch: got cnt=%0d resync=%b, required 0/0", grp_err_cnt_o[3:2], grp_resync_req_o[1]);
        end
        harts_sync_req_i[4:2] = 3'b111;
        grp_enable_i[1] = 1'b1;
        expect_ev(EV_SETBACK, 1, SB);
        tick(2);
        checks++;
        if (core_setback_o[4:2] !== 3'b011) begin errors++; $display("FAIL leftover_setback: got %b, required 011", core_setback_o[4:2]); end
        harts_sync_req_i[4] = 1'b0;
        tick(SB);
        checks++;
        if (grp_locked_o[1] !== 1'b1 || core_setback_o[4] !== 1'b0) begin
            errors++;
            $display("FAIL group1_lock: got locked=%b hart4=%b, required 1/0", grp_locked_o[1], core_setback_o[4]);
        end
        harts_sync_req_i[4] = 1'b1;
        grp_mismatch_i[1] = 1'b1;
        grp_enable_i[1] = 1'b0;
        exp_err[1] = exp_err[1] + 1'b1;
        tick(1);
        grp_mismatch_i[1] = 1'b0;
        checks++;
        if (grp_locked_o[1] !== 1'b0 || grp_resync_req_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_disable_state: got locked=%b resync=%b, required 0/0", grp_locked_o[1], grp_resync_req_o[1]);
        end
        checks++;
        if (grp_err_cnt_o[3:2] !== exp_err[1]) begin errors++; $display("FAIL mismatch_disable_cnt: got %0d, required %0d", grp_err_cnt_o[3:2], exp_err[1]); end
        tick(2);
        checks++;
        if (grp_locked_o !== 2'b01 || core_setback_o !== '0) begin
            errors++;
            $display("FAIL stay_idle: got locked=%b setback=%b, required 01/00000", grp_locked_o, core_setback_o);
        end
    endtask

    task automatic test_reset_mid_setback();
        grp_enable_i[0] = 1'b0;
        tick(1);
        grp_enable_i[0] = 1'b1;
        tick(2);
        checks++;
        if (core_setback_o[1:0] !== 2'b11) begin errors++; $display("FAIL resetup_setback: got %b, required 11", core_setback_o[1:0]); end
        tick(1);
        #1;
        rstn_i = 1'b0;
        #1;
        checks++;
        if (core_setback_o !== '0 || grp_locked_o !== '0 || grp_resync_req_o !== '0 ||
            grp_timeout_o !== '0 || grp_err_cnt_o !== '0) begin
            errors++;
            $display("FAIL async_reset: got sb=%b lk=%b rs=%b to=%b cnt=%h, required all 0",
                     core_setback_o, grp_locked_o, grp_resync_req_o, grp_timeout_o, grp_err_cnt_o);
        end
        grp_enable_i     = '0;
        harts_sync_req_i = '0;
        tick(2);
        rstn_i = 1'b1;
        tick(3);
        checks++;
        if (core_setback_o !== '0 || grp_locked_o !== '0 || grp_err_cnt_o !== '0) begin
            errors++;
            $display("FAIL post_reset: got sb=%b lk=%b cnt=%h, required all 0", core_setback_o, grp_locked_o, grp_err_cnt_o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rstn_i           = 1'b0;
        grp_enable_i     = '0;
        harts_sync_req_i = '0;
        grp_mismatch_i   = '0;
        for (int g = 0; g < NG; g++) exp_err[g] = '0;
        tick(3);
        rstn_i = 1'b1;
        tick(1);

        test_reset();
        test_sync_lock();
        test_mismatch_count();
        test_saturation();
        test_timeout();
        test_leftover_and_disable();
        test_reset_mid_setback();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d unmatched expected events, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
